adpt_seg: RTL and testbench

Output-side board adapter that drives the 8-digit multiplexed seven-segment display from a 32-bit value, one hex nibble per digit. It complements the switch and LED adapters: lab circuits present a value here, and the block handles the scanning, hex decode, and active-low board polarity. A load-shadow/frame-copy buffer keeps the display from tearing when the value changes mid-scan.

---
 rtl/adpt_seg.sv | 83 ++++++++
 tb/tb_adpt_seg.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/adpt_seg.sv
// Scans a 32-bit hex value onto an 8-digit active-low seven-segment display; the value shown is copied from the load shadow only at frame wrap.
// an/seg are registered and change together with the digit index, every SCAN_DIV cycles; no backpressure (load is always accepted).
module adpt_seg #(
  parameter int SCAN_DIV = 100_000
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic [7:0]  dp,
  input  logic [7:0]  dig_en,
  input  logic        lz_blank,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] TERM = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx, idx_nx;
  logic [31:0]   shadow, disp, disp_nx, hi;
  logic [3:0]    nib;
  logic          step, wrap, blanked, lit;
  logic [7:0]    an_nx, seg_nx;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Outputs are built from the post-step idx/disp so they switch on the same edge as idx.
  always_comb begin
    step    = (cnt == TERM);
    wrap    = step && (idx == 3'd7);
    idx_nx  = idx + 3'd1;
    disp_nx = wrap ? shadow : disp;
    nib     = disp_nx[{idx_nx, 2'b00} +: 4];
    hi      = disp_nx >> {idx_nx, 2'b00};
    blanked = lz_blank && (idx_nx != 3'd0) && (hi == 32'd0);
    lit     = dig_en[idx_nx] && !blanked;
    an_nx   = 8'hFF;
    seg_nx  = 8'hFF;
    if (lit) begin
      an_nx  = ~(8'h01 << idx_nx);
      seg_nx = {~dp[idx_nx], hex7(nib)};
    end
  end

  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      idx    <= 3'd0;
      shadow <= 32'd0;
      disp   <= 32'd0;
      frame  <= 1'b0;
      an     <= 8'hFF;
      seg    <= 8'hFF;
    end else begin
      if (load) shadow <= data_in;
      frame <= wrap;
      if (step) begin
        cnt  <= '0;
        idx  <= idx_nx;
        disp <= disp_nx;
        an   <= an_nx;
        seg  <= seg_nx;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_adpt_seg.sv
// Self-checking bench for adpt_seg with SCAN_DIV=4: frame-level reference model, vector table and corner sequences.
module tb_adpt_seg;
  localparam int SD = 4;
  localparam int FR = 8 * SD;

  logic        clk_100M = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = 32'd0;
  logic        load = 1'b0;
  logic [7:0]  dp = 8'h00;
  logic [7:0]  dig_en = 8'hFF;
  logic        lz_blank = 1'b0;
  logic [7:0]  an, seg;
  logic        frame;

  adpt_seg #(.SCAN_DIV(SD)) dut (
    .clk_100M(clk_100M), .rst(rst), .data_in(data_in), .load(load), .dp(dp),
    .dig_en(dig_en), .lz_blank(lz_blank), .an(an), .seg(seg), .frame(frame)
  );

  always #5 clk_100M = ~clk_100M;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int n_tests = 0;
  int n_fail  = 0;

  // Model: t counts edges since reset release; slot = t/SD, copy every FR edges.
  int          t = 0;
  logic [31:0] shadow_m = 32'd0, disp_m = 32'd0;
  logic [7:0]  an_m = 8'hFF, seg_m = 8'hFF;
  logic        frame_m = 1'b0;

  typedef struct {
    logic [31:0]     val;
    logic [7:0]      dpv;
    logic [7:0]      en;
    logic            lz;
    logic [7:0][7:0] ex_an;
    logic [7:0][7:0] ex_seg;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %h expected %h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; shadow_m = 32'd0; disp_m = 32'd0;
    an_m = 8'hFF; seg_m = 8'hFF; frame_m = 1'b0;
  endtask

  task automatic tick();
    int i;
    logic lit;
    @(posedge clk_100M);
    if (rst) begin
      t++;
      frame_m = (t % FR == 0);
      if (frame_m) disp_m = shadow_m;
      if (load) shadow_m = data_in;
      if (t % SD == 0) begin
        i = (t / SD) % 8;
        lit = dig_en[i] && !(lz_blank && i != 0 && (disp_m / (64'd1 << (4 * i))) == 0);
        if (lit) begin
          an_m  = 8'hFF ^ (8'd1 << i);
          seg_m = hex_tab[(disp_m >> (4 * i)) & 32'hF];
          if (dp[i]) seg_m[7] = 1'b0;
        end else begin
          an_m = 8'hFF; seg_m = 8'hFF;
        end
      end
    end
    @(negedge clk_100M);
    check("model_an", an, an_m);
    check("model_seg", seg, seg_m);
    check("model_frame", frame, frame_m);
  endtask

  task automatic wait_frame();
    bit seen = 0;
    for (int k = 0; k < FR + SD && !seen; k++) begin
      tick();
      if (frame === 1'b1) seen = 1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_frame: no frame pulse within %0d cycles", FR + SD);
    end
  endtask

  task automatic load_val(input logic [31:0] v);
    data_in = v; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h89AB_CDEF, 8'h00, 8'hFF, 1'b0, 64'h7FBF_DFEF_F7FB_FDFE, 64'h8090_8883_C6A1_868E};
    vecs[1] = '{32'h0000_0050, 8'h00, 8'hFF, 1'b1, 64'hFFFF_FFFF_FFFF_FDFE, 64'hFFFF_FFFF_FFFF_92C0};
    vecs[2] = '{32'h0000_0050, 8'h00, 8'hFF, 1'b0, 64'h7FBF_DFEF_F7FB_FDFE, 64'hC0C0_C0C0_C0C0_92C0};
    vecs[3] = '{32'h0000_0012, 8'h02, 8'hFE, 1'b0, 64'h7FBF_DFEF_F7FB_FDFF, 64'hC0C0_C0C0_C0C0_79FF};

    // Reset and first scan step
    #1 rst = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_an", an, 8'hFF); check("rst_seg", seg, 8'hFF); check("rst_frame", frame, 1'b0);
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("pre_step_an", an, 8'hFF);
    end
    tick();
    check("first_step_an", an, 8'hFD);
    check("first_step_seg", seg, 8'hC0);

    // Vector table: load, then one full frame of expected slots
    foreach (vecs[v]) begin
      wait_frame();
      dp = vecs[v].dpv; dig_en = vecs[v].en; lz_blank = vecs[v].lz;
      load_val(vecs[v].val);
      wait_frame();
      for (int s = 0; s < 8; s++)
        for (int c = 0; c < SD; c++) begin
          check("vec_an", an, vecs[v].ex_an[s]);
          check("vec_seg", seg, vecs[v].ex_seg[s]);
          tick();
        end
    end

    // Tearing: second load mid-frame must not show until the next frame
    dp = 8'h00; dig_en = 8'hFF; lz_blank = 1'b0;
    wait_frame();
    load_val(32'h1111_1111);
    wait_frame();
    for (int k = 0; k < FR && (t % FR) != 3 * SD; k++) tick();
    load_val(32'h2222_2222);
    for (int k = 0; k < FR - 3 * SD - 1; k++) begin
      check("tear_cur_seg", seg, 8'hF9);
      tick();
    end
    check("tear_frame", frame, 1'b1);
    for (int k = 0; k < FR; k++) begin
      check("tear_next_seg", seg, 8'hA4);
      tick();
    end

    // Load coincident with the frame copy
    for (int k = 0; k < FR && (t % FR) != FR - 1; k++) tick();
    data_in = 32'h5555_5555; load = 1'b1;
    tick();
    load = 1'b0;
    check("simul_frame", frame, 1'b1);
    for (int k = 0; k < FR; k++) begin
      check("simul_old_seg", seg, 8'hA4);
      tick();
    end
    for (int k = 0; k < FR; k++) begin
      check("simul_new_seg", seg, 8'h92);
      tick();
    end

    // Random stimulus against the model
    for (int k = 0; k < 1500; k++) begin
      data_in = $urandom;
      load = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) begin
        dp = 8'($urandom); dig_en = 8'($urandom); lz_blank = 1'($urandom);
        if ($urandom_range(0, 1) == 0) data_in = data_in >> (4 * $urandom_range(0, 7));
      end
      tick();
    end
    load = 1'b0; dp = 8'h00; dig_en = 8'hFF; lz_blank = 1'b0;

    // Asynchronous reset mid-frame
    load_val(32'h9876_5432);
    wait_frame();
    for (int k = 0; k < 13; k++) tick();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_an", an, 8'hFF);
    check("async_rst_seg", seg, 8'hFF);
    check("async_rst_frame", frame, 1'b0);
    tick();
    rst = 1'b1;
    wait_frame();
    for (int k = 0; k < FR; k++) begin
      check("post_rst_seg", seg, 8'hC0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
